mda_attr_serializer: RTL

- Parametrised successor to the MDA character pixel path. Captures one glyph row byte plus attribute byte per character cell and serialises it to pixels.
- Applies the full MDA attribute set: normal, reverse, invisible, underline, intensity, blink.
- Adds 9th-column line-graphics duplication, synchronous frame-based blink timing, and an optional hardware cursor.
- Sits between the character ROM/RAM fetch and the video/inten output pins, in the pixel clock domain.

---
 rtl/mda_pkg.sv | 41 ++++
 rtl/mda_blink_timer.sv | 36 +++
 rtl/mda_attr_serializer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mda_pkg.sv
// Shared definitions for the MDA attribute serializer: attribute field
// constants, the line-graphics code range and the decoded cell mode.
package mda_pkg;

    localparam int         ATTR_BLINK_BIT = 7;
    localparam int         ATTR_INTEN_BIT = 3;
    localparam logic [2:0] ATTR_UL        = 3'b001;
    localparam logic [7:0] ATTR_FG_MASK   = 8'h07;
    localparam logic [7:0] ATTR_BG_MASK   = 8'h70;

    // Character codes whose 9th column repeats the 8th (box drawing).
    localparam logic [7:0] LINE_GFX_LO = 8'hC0;
    localparam logic [7:0] LINE_GFX_HI = 8'hDF;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        REVERSE   = 2'd1,
        INVISIBLE = 2'd2,
        UNDERLINE = 2'd3
    } cell_mode_t;

    // Decode an attribute byte in priority order. UNDERLINE only means the
    // foreground field asks for it; the scan-line match is done by the caller.
    function automatic cell_mode_t decode_mode(input logic [7:0] a);
        logic [7:0] fg;
        logic [7:0] bg;
        fg = a & ATTR_FG_MASK;
        bg = a & ATTR_BG_MASK;
        if ((bg == 8'h00) && (fg == 8'h00)) begin
            return INVISIBLE;
        end
        if ((bg == ATTR_BG_MASK) && (fg == 8'h00)) begin
            return REVERSE;
        end
        if (a[2:0] == ATTR_UL) begin
            return UNDERLINE;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/mda_blink_timer.sv
// Frame counter for blink timing: counts rising edges of vertical sync and
// exposes the character blink phase (MSB) and cursor blink phase (MSB-1).
module mda_blink_timer #(
    parameter int BLINK_BITS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vs,
    output logic o_char_phase,
    output logic o_cur_phase
);

    logic                  r_vs_q;
    logic [BLINK_BITS-1:0] r_cnt;
    logic                  w_vs_rise;

    // A long vs pulse counts once: only the low-to-high transition matters.
    assign w_vs_rise = i_vs & ~r_vs_q;

    // Register vs history and advance the frame counter on each new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_q <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_vs_q <= i_vs;
            if (w_vs_rise) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_char_phase = r_cnt[BLINK_BITS-1];
    assign o_cur_phase  = r_cnt[BLINK_BITS-2];

endmodule

// File: rtl/mda_attr_serializer.sv
// MDA character pixel path: captures glyph row + attribute per cell and
// serialises it with attribute, blink, 9th-column and (optionally) cursor
// processing. Hardware cursor is built only when MDA_CURSOR_EN is defined.
module mda_attr_serializer
    import mda_pkg::*;
#(
    parameter int CHAR_W     = 9,
    parameter int CHAR_H     = 14,
    parameter int UL_ROW     = 13,
    parameter int BLINK_BITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld,
    input  logic [7:0]                glyph,
    input  logic [7:0]                code,
    input  logic [7:0]                attr,
    input  logic [$clog2(CHAR_H)-1:0] char_row,
    input  logic                      de,
    input  logic                      vs,
    input  logic                      cur_hit,
    input  logic [$clog2(CHAR_H)-1:0] cur_start,
    input  logic [$clog2(CHAR_H)-1:0] cur_end,
    output logic                      video,
    output logic                      inten
);

    localparam int ROW_W = $clog2(CHAR_H);
    localparam int CNT_W = 4;
    localparam logic [ROW_W-1:0] UL_ROW_V = ROW_W'(UL_ROW);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(CHAR_W - 1);

    // Captured cell state. The shift register holds the pixels still to be
    // shown after the first one, which goes out straight from the inputs.
    logic [8:0]       r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_attr;
    logic [ROW_W-1:0] r_row;
    logic             r_char_phase;
    logic             r_video;
    logic             r_inten;

    logic [8:0]       w_shift_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       w_attr_sel;
    logic [ROW_W-1:0] w_row_sel;
    logic             w_char_phase_live;
    logic             w_cur_phase_live;
    logic             w_char_phase;
    logic             w_bit;
    logic             w_bit9;
    logic             w_valid;
    cell_mode_t       w_mode;
    logic             w_raw;
    logic             w_video_next;
    logic             w_inten_next;

    mda_blink_timer #(
        .BLINK_BITS (BLINK_BITS)
    ) u_blink (
        .clk          (clk),
        .rst          (rst),
        .i_vs         (vs),
        .o_char_phase (w_char_phase_live),
        .o_cur_phase  (w_cur_phase_live)
    );

`ifdef MDA_CURSOR_EN
    logic r_cur_hit;
    logic r_cur_phase;
    logic w_cur_hit_sel;
    logic w_cur_phase;

    // Cursor state is captured with the cell so the whole cell sees one phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_hit   <= 1'b0;
            r_cur_phase <= 1'b0;
        end else if (ld) begin
            r_cur_hit   <= cur_hit;
            r_cur_phase <= w_cur_phase_live;
        end
    end

    assign w_cur_hit_sel = ld ? cur_hit          : r_cur_hit;
    assign w_cur_phase   = ld ? w_cur_phase_live : r_cur_phase;
`else
    logic w_unused;
    assign w_unused = &{1'b0, cur_hit, cur_start, cur_end, w_cur_phase_live};
`endif

    // On a load cycle the new cell's inputs drive the pixel directly, which
    // gives the single cycle of latency and lets an early ld cut a cell short.
    always_comb begin
        w_attr_sel   = ld ? attr : r_attr;
        w_row_sel    = ld ? char_row : r_row;
        w_char_phase = ld ? w_char_phase_live : r_char_phase;
        w_bit        = ld ? glyph[7] : r_shift[8];
        w_valid      = ld | (r_cnt != '0);
        w_mode       = decode_mode(w_attr_sel);

        w_bit9 = 1'b0;
        if ((CHAR_W == 9) && (code >= LINE_GFX_LO) && (code <= LINE_GFX_HI)) begin
            w_bit9 = glyph[0];
        end

        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        if (ld) begin
            w_shift_next = {glyph[6:0], w_bit9, 1'b0};
            w_cnt_next   = LAST_PIX;
        end else if (r_cnt != '0) begin
            w_shift_next = {r_shift[7:0], 1'b0};
            w_cnt_next   = r_cnt - 1'b1;
        end
    end

    // Attribute decode, blink suppression, cursor overlay and de gating.
    always_comb begin
        w_raw = 1'b0;
        case (w_mode)
            INVISIBLE: w_raw = 1'b0;
            REVERSE:   w_raw = ~w_bit;
            UNDERLINE: w_raw = (w_row_sel == UL_ROW_V) ? 1'b1 : w_bit;
            default:   w_raw = w_bit;
        endcase

        // Blink-off phase hides the foreground; for reverse cells the hidden
        // foreground leaves the lit background, i.e. a solid block.
        if (w_attr_sel[ATTR_BLINK_BIT] && !w_char_phase) begin
            w_raw = (w_mode == REVERSE);
        end

        if (!w_valid) begin
            w_raw = 1'b0;
        end

`ifdef MDA_CURSOR_EN
        if (w_valid && w_cur_hit_sel && w_cur_phase &&
            (cur_start <= w_row_sel) && (w_row_sel <= cur_end)) begin
            w_raw = 1'b1;
        end
`endif

        w_video_next = w_raw & de;
        w_inten_next = w_attr_sel[ATTR_INTEN_BIT] & de;
    end

    // Cell capture, pixel shifting and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_attr       <= '0;
            r_row        <= '0;
            r_char_phase <= 1'b0;
            r_video      <= 1'b0;
            r_inten      <= 1'b0;
        end else begin
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
            r_video <= w_video_next;
            r_inten <= w_inten_next;
            if (ld) begin
                r_attr       <= attr;
                r_row        <= char_row;
                r_char_phase <= w_char_phase_live;
            end
        end
    end

    assign video = r_video;
    assign inten = r_inten;

endmodule
